// File: rtl/lsu_unit.sv
// lsu_unit: RV32I load/store unit that runs one data-memory access at a time and drives load writeback.
// Optional build define LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of ignoring low bits.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_num,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_write,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_WB = 2'd3} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] ofs);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << ofs;
      2'b01:   be = 4'b0011 << {ofs[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{wdata[7:0]}};
      2'b01:   wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{ofs, 3'b000} +: 8];
    h = rdata[{ofs[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ofs);
    logic m;
    case (f3[1:0])
      2'b01:   m = ofs[0];
      2'b10:   m = (ofs != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic             ready_r, mem_valid_r, done_r, err_r, wb_write_r;
  logic             mem_valid_nxt_s, done_nxt_s, err_nxt_s, wb_write_nxt_s;
  logic             capture_s, take_s, accept_s, bad_s, timeout_s;
  logic [31:0]      ea_s;
  logic [1:0]       ea_lo_r;
  logic [2:0]       f3_r;
  logic             st_r, mem_we_r;
  logic [4:0]       rd_r, wb_rd_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, wb_data_r;
  logic [3:0]       mem_be_r;

  assign ea_s      = req_base + req_offset;
  assign accept_s  = req_valid && ready_r;
  assign cnt_inc_s = cnt_r + CNT_W'(1'b1);
  assign timeout_s = TO_EN && (cnt_r == TO_LAST);
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_s = !f3_legal(req_is_store, req_funct3) || misaligned(req_funct3, ea_s[1:0]);
`else
  assign bad_s = !f3_legal(req_is_store, req_funct3);
`endif

  // Next-state and next-output decode; timeout takes priority over memory responses.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    mem_valid_nxt_s = 1'b0;
    done_nxt_s      = 1'b0;
    err_nxt_s       = 1'b0;
    wb_write_nxt_s  = 1'b0;
    capture_s       = 1'b0;
    take_s          = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s && bad_s) begin
          err_nxt_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s     = S_REQ;
          mem_valid_nxt_s = 1'b1;
          cnt_nxt_s       = {CNT_W{1'b0}};
          capture_s       = 1'b1;
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      S_REQ: begin
        cnt_nxt_s = cnt_inc_s;
        if (timeout_s) begin
          state_nxt_s = S_IDLE;
          err_nxt_s   = 1'b1;
        end else if (mem_ready && st_r) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = 1'b1;
        end else if (mem_ready) begin
          state_nxt_s = S_WAIT;
        end else begin
          mem_valid_nxt_s = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_nxt_s = cnt_inc_s;
        if (timeout_s) begin
          state_nxt_s = S_IDLE;
          err_nxt_s   = 1'b1;
        end else if (mem_rvalid) begin
          state_nxt_s    = S_WB;
          done_nxt_s     = 1'b1;
          wb_write_nxt_s = (rd_r != 5'd0);
          take_s         = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_WB:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Control state, timeout counter and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      ready_r     <= 1'b1;
      mem_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wb_write_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ready_r     <= (state_nxt_s == S_IDLE);
      mem_valid_r <= mem_valid_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      wb_write_r  <= wb_write_nxt_s;
    end
  end

  // Access capture on accept; writeback registers only move when a real write happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_lo_r     <= 2'b00;
      f3_r        <= 3'b000;
      st_r        <= 1'b0;
      rd_r        <= 5'd0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'b0000;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
      wb_data_r   <= 32'd0;
      wb_rd_r     <= 5'd0;
    end else begin
      if (capture_s) begin
        ea_lo_r     <= ea_s[1:0];
        f3_r        <= req_funct3;
        st_r        <= req_is_store;
        rd_r        <= req_rd_num;
        mem_addr_r  <= {ea_s[31:2], 2'b00};
        mem_be_r    <= lane_be(req_funct3, ea_s[1:0]);
        mem_we_r    <= req_is_store;
        mem_wdata_r <= req_is_store ? lane_wdata(req_funct3, req_wdata) : 32'd0;
      end
      if (take_s && (rd_r != 5'd0)) begin
        wb_data_r <= load_ext(f3_r, ea_lo_r, mem_rdata);
        wb_rd_r   <= rd_r;
      end
    end
  end

  assign req_ready = ready_r;
  assign mem_valid = mem_valid_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_write  = wb_write_r;
  assign wb_rd_num = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed cases plus randomized accesses against an arithmetic reference model.
module tb_lsu_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_base = 32'd0, req_offset = 32'd0, req_wdata = 32'd0;
  logic [4:0]  req_rd_num = 5'd0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        req_ready, mem_valid, mem_we, wb_write, done, err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd_num;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_wb_data = 32'd0;
  logic [4:0]  last_wb_rd = 5'd0;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_rd_num(req_rd_num),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_write(wb_write), .wb_rd_num(wb_rd_num), .wb_data(wb_data), .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: access size in bytes, lane start byte, plain arithmetic extraction.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (!st && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_lane(input logic [2:0] f3, input logic [31:0] ea);
    int sz = m_size(f3);
    return int'(ea % 4) / sz * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] ea);
    int sz = m_size(f3);
    return 4'(((1 << sz) - 1) << m_lane(f3, ea));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    int sz = m_size(f3);
    longint mask, v;
    mask = (longint'(1) << (8 * sz)) - 1;
    v = longint'({32'd0, wd}) & mask;
    if (sz == 1) v = v * 64'h0101_0101;
    if (sz == 2) v = v * 64'h0001_0001;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rd);
    int sz = m_size(f3);
    longint mask, v;
    mask = (longint'(1) << (8 * sz)) - 1;
    v = (longint'({32'd0, rd}) >> (8 * m_lane(f3, ea))) & mask;
    if (f3 < 3'd4 && sz < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    return v[31:0];
  endfunction

  task automatic run_op(input string tag, input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int d1, input int d2);
    logic [31:0] ea;
    bit bad;
    ea = base + off;
    bad = !m_legal(st, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && (ea % m_size(f3)) != 0) bad = 1'b1;
`endif
    check_eq({tag, "/ready"}, req_ready, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_wdata = wd; req_rd_num = rd;
    @(negedge clk);
    req_valid = 1'b0; req_base = $urandom; req_offset = $urandom; req_wdata = $urandom;
    req_rd_num = 5'($urandom); req_funct3 = 3'($urandom); req_is_store = 1'($urandom);
    check_eq({tag, "/err"}, err, 32'(bad));
    if (bad) begin
      check_eq({tag, "/noreq"}, mem_valid, 32'd0);
      @(negedge clk);
      check_eq({tag, "/err_end"}, {mem_valid, err, req_ready}, 32'b001);
      return;
    end
    for (int i = 0; i <= d1; i++) begin
      mem_ready = (i == d1);
      mem_rvalid = 1'($urandom);
      check_eq({tag, "/mvalid"}, mem_valid, 32'd1);
      check_eq({tag, "/addr"}, mem_addr, {ea[31:2], 2'b00});
      check_eq({tag, "/be"}, mem_be, 32'(m_be(f3, ea)));
      check_eq({tag, "/we"}, mem_we, 32'(st));
      if (st) check_eq({tag, "/wdata"}, mem_wdata, m_wd(f3, wd));
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    if (st) begin
      check_eq({tag, "/st_done"}, {done, mem_valid, wb_write, err}, 32'b1000);
      @(negedge clk);
      check_eq({tag, "/st_end"}, {done, req_ready}, 32'b01);
      return;
    end
    for (int i = 0; i <= d2; i++) begin
      mem_rvalid = (i == d2);
      mem_rdata = (i == d2) ? rdata : $urandom;
      check_eq({tag, "/wait"}, {mem_valid, done, wb_write}, 32'b000);
      @(negedge clk);
    end
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check_eq({tag, "/ld_done"}, {done, err, wb_write}, {29'd0, 2'b10, rd != 5'd0});
    if (rd != 5'd0) begin
      last_wb_data = m_load(f3, ea, rdata);
      last_wb_rd = rd;
    end
    check_eq({tag, "/wb_data"}, wb_data, last_wb_data);
    check_eq({tag, "/wb_rd"}, wb_rd_num, 32'(last_wb_rd));
    @(negedge clk);
    check_eq({tag, "/ld_end"}, {done, wb_write, req_ready}, 32'b001);
    check_eq({tag, "/wb_hold"}, wb_data, last_wb_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] off;
    int k, d1, d2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset/ready", req_ready, 32'd1);
    check_eq("reset/ctl", {mem_valid, mem_we, wb_write, done, err}, 32'd0);
    check_eq("reset/mem", {mem_be, mem_addr[27:0]} | mem_wdata, 32'd0);
    check_eq("reset/wb", wb_data | 32'(wb_rd_num), 32'd0);

    run_op("sw",    1'b1, 3'd2, 32'h100, 32'd4, 32'hDEADBEEF, 5'd0, 32'd0, 0, 0);
    run_op("sb",    1'b1, 3'd0, 32'h200, 32'd3, 32'h000000A5, 5'd0, 32'd0, 0, 0);
    run_op("lb",    1'b0, 3'd0, 32'h300, 32'd2, 32'd0, 5'd5, 32'h12807856, 0, 0);
    run_op("lbu",   1'b0, 3'd4, 32'h300, 32'd2, 32'd0, 5'd5, 32'h12807856, 0, 0);
    run_op("lh_r0", 1'b0, 3'd1, 32'h0,   32'd0, 32'd0, 5'd0, 32'h0000FFFE, 0, 0);
    run_op("lhu",   1'b0, 3'd5, 32'h0,   32'd2, 32'd0, 5'd9, 32'h8001ABCD, 1, 0);
    run_op("wrap",  1'b0, 3'd2, 32'hFFFFFFFE, 32'd4, 32'd0, 5'd3, 32'hCAFEF00D, 0, 1);
    run_op("ld011", 1'b0, 3'd3, 32'h40,  32'd0, 32'd0, 5'd4, 32'd0, 0, 0);
    run_op("sb100", 1'b1, 3'd4, 32'h40,  32'd0, 32'd7, 5'd0, 32'd0, 0, 0);
    run_op("lw_mis", 1'b0, 3'd2, 32'h100, 32'd1, 32'd0, 5'd6, 32'h89ABCDEF, 0, 0);
    run_op("lh_mis", 1'b0, 3'd1, 32'h100, 32'd3, 32'd0, 5'd7, 32'h89ABCDEF, 0, 0);

    // Timeout: handshake immediately, rvalid never arrives.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_base = 32'h500;
    req_offset = 32'd0; req_rd_num = 5'd11;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      check_eq($sformatf("timeout/err_c%0d", i), err, 32'(i == TO));
      check_eq($sformatf("timeout/mvalid_c%0d", i), {mem_valid, wb_write, done}, 32'd0);
    end
    check_eq("timeout/ready", req_ready, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("timeout/late_rvalid", {wb_write, done, err}, 32'd0);
    check_eq("timeout/wb_hold", wb_data, last_wb_data);

    // Reset while waiting for read data.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_base = 32'h600;
    req_offset = 32'd8; req_rd_num = 5'd12;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wait/ctl", {mem_valid, mem_we, wb_write, done, err}, 32'd0);
    check_eq("rst_wait/addr", mem_addr, 32'd0);
    check_eq("rst_wait/wb", wb_data | 32'(wb_rd_num), 32'd0);
    last_wb_data = 32'd0; last_wb_rd = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_eq("rst_wait/no_wb", {wb_write, done, err}, 32'd0);
    end
    check_eq("rst_wait/ready", req_ready, 32'd1);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      off = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) - 32'd16 : 32'($urandom);
      d1 = st ? $urandom_range(0, 2) : $urandom_range(0, 1);
      d2 = (d1 != 0) ? 0 : $urandom_range(0, 1);
      run_op($sformatf("rnd%0d", n), st, f3, $urandom, off, $urandom, 5'($urandom), $urandom, d1, d2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
